joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 SHALL have parameter BITS_PER_PLAYER, default 12: number of button bits serialised per player.
REQ-002 SHALL have parameter PLAYERS, default 2: number of players per frame; frame length is PLAYERS*BITS_PER_PLAYER (24).
REQ-003 SHALL have port clk, input, 1 bit: single clock, 40-50 MHz.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port joystick1, input, 16 bits: player-1 buttons, active-high, bits 0..11 = R,L,D,U,A,B,C,D,E,F,Start,Select; bits 15:12 unused.
REQ-006 SHALL have port joystick2, input, 16 bits: player-2 buttons, same layout as joystick1.
REQ-007 SHALL have port JOY_CLK, input, 1 bit: host shift clock, asynchronous to clk.
REQ-008 SHALL have port JOY_LOAD, input, 1 bit: host parallel-load strobe, active-low, asynchronous to clk.
REQ-009 SHALL have port JOY_DATA, output, 1 bit: serial button data, active-low (0 = pressed).
REQ-010 SHALL have port frame_done, output, 1 bit: one-clk pulse when the final frame bit has been shifted past.
REQ-011 SHALL have port bit_cnt, output, 5 bits: index of the bit currently on JOY_DATA.

Function
REQ-012 SHALL model the adapter's 74HC165 chain: the host-side receiver decodes the stream unchanged.
REQ-013 While synchronised JOY_LOAD is low, SHALL reload the 24-bit shift register every clk with {~joystick2[11:0], ~joystick1[11:0]} (transparent load), set bit_cnt=0, and drive JOY_DATA=~joystick1[0].
REQ-014 SHALL ignore JOY_CLK rising edges while JOY_LOAD is low.
REQ-015 On a synchronised JOY_CLK rising edge with JOY_LOAD high, SHALL shift one position toward JOY_DATA, fill with 1, and increment bit_cnt (saturating at 24).
REQ-016 Bit order on JOY_DATA after load SHALL be P1 bit0..bit11, then P2 bit0..bit11.
REQ-017 On the edge that moves bit_cnt from 23 to 24, SHALL pulse frame_done for exactly one clk.
REQ-018 With bit_cnt=24, SHALL hold JOY_DATA=1; further JOY_CLK edges SHALL change nothing and SHALL raise no further frame_done.
REQ-019 If the JOY_LOAD falling edge and a JOY_CLK rising edge are detected in the same clk, load SHALL win.
REQ-020 A load mid-frame SHALL abort the frame; frame_done SHALL NOT pulse for the aborted frame.
REQ-021 Button changes after JOY_LOAD rises SHALL NOT affect the frame in progress.
REQ-022 Latency from a JOY_CLK/JOY_LOAD pin edge to the JOY_DATA update SHALL be 3 clk with JOY_DB15_TX_SYNC_EN defined and 1 clk without it.

Reset
REQ-023 reset SHALL set the shift register to all ones, JOY_DATA=1, bit_cnt=24, frame_done=0, and synchroniser/edge flops to 1.
REQ-024 reset asserted mid-frame SHALL abort the frame with no frame_done pulse; the first valid frame after reset SHALL start at the next load.

Configuration
REQ-025 Macro JOY_DB15_TX_SYNC_EN defined: JOY_CLK and JOY_LOAD SHALL each pass through a 2-flop synchroniser before edge detection.
REQ-026 Macro JOY_DB15_TX_SYNC_EN undefined: pins SHALL feed the edge-detect register directly, for same-clock loopback benches only.

Structure
REQ-027 Shared package joy_db15_pkg SHALL hold the button bit-index constants (R..Select), BITS_PER_PLAYER, PLAYERS and the frame length constant.
REQ-028 A single sub-module joy_db15_sync SHALL implement the synchroniser plus registered rise/fall detection and SHALL be instantiated once per input.
REQ-029 The shift register, bit counter and frame_done logic SHALL reside in joy_db15_tx.

Verification
REQ-030 Load-and-shift: joystick1=16'h0011, joystick2=16'h0800, load pulse, then 24 clocks -> JOY_DATA sequence 0,1,1,1,0,1,1,1,1,1,1,1, then eleven 1s, then 0; frame_done pulses once after clock 24.
REQ-031 Loopback: connect to joy_db15 receiver, joystick1=16'h0A5A, joystick2=16'h05A5 -> receiver outputs joystick1[11:0]=12'hA5A and joystick2[11:0]=12'h5A5 within 2 frames.
REQ-032 Overrun: 30 JOY_CLK edges after load -> JOY_DATA=1 for edges 24-30, bit_cnt=24, exactly one frame_done.
REQ-033 Mid-frame reload: load after 10 edges, joystick1 changed to 16'h0002 -> JOY_DATA=1 then 0 on the next two bits, bit_cnt restarts at 0, no frame_done for the aborted frame.
REQ-034 Collision: JOY_CLK rise and JOY_LOAD fall in the same clk -> bit_cnt=0, no shift.
REQ-035 Reset: reset at bit_cnt=7 -> the next clk shows JOY_DATA=1, bit_cnt=24, frame_done=0; with sync enabled, measured pin-to-JOY_DATA latency is 3 clk.

Source files
------------

// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: button bit indices and frame geometry shared by the DB15 joystick transmitter.
package joy_db15_pkg;
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_D2 = 7;
  localparam int BTN_E = 8;
  localparam int BTN_F = 9;
  localparam int BTN_START = 10;
  localparam int BTN_SELECT = 11;
  localparam int BITS_PER_PLAYER = 12;
  localparam int PLAYERS = 2;
  localparam int FRAME_LEN = BITS_PER_PLAYER * PLAYERS;
endpackage

// File: rtl/joy_db15_sync.sv
// joy_db15_sync: optional 2-flop synchroniser (JOY_DB15_TX_SYNC_EN) followed by rise/fall detection.
module joy_db15_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
`ifdef JOY_DB15_TX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk) r_sync <= reset ? 2'b11 : {r_sync[0], i_pin};
  assign o_lvl = r_sync[1];
`else
  assign o_lvl = i_pin;
`endif
  logic r_prev;
  always_ff @(posedge clk) r_prev <= reset ? 1'b1 : o_lvl;
  assign o_rise = o_lvl & ~r_prev;
  assign o_fall = ~o_lvl & r_prev;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: 74HC165-chain model serialising two joysticks onto JOY_DATA (active-low).
// Define JOY_DB15_TX_SYNC_EN to synchronise JOY_CLK/JOY_LOAD from an asynchronous host.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int BITS_PER_PLAYER = joy_db15_pkg::BITS_PER_PLAYER,
  parameter int PLAYERS = joy_db15_pkg::PLAYERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic [4:0]  bit_cnt
);
  localparam int FL = PLAYERS * BITS_PER_PLAYER;
  localparam logic [4:0] CNT_END = 5'(FL);
  logic w_clk_lvl, w_clk_rise, w_clk_fall, w_load_lvl, w_load_rise, w_load_fall, w_unused;
  logic [FL-1:0] r_sr, w_par;
  logic [4:0] r_cnt;
  logic r_done;
  joy_db15_sync u_clk (.clk(clk), .reset(reset), .i_pin(JOY_CLK), .o_lvl(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall));
  joy_db15_sync u_load (.clk(clk), .reset(reset), .i_pin(JOY_LOAD), .o_lvl(w_load_lvl), .o_rise(w_load_rise), .o_fall(w_load_fall));
  always_comb begin
    w_par = '1;
    for (int p = 0; p < PLAYERS; p++)
      w_par[p*BITS_PER_PLAYER +: BITS_PER_PLAYER] = p == 0 ? ~joystick1[BITS_PER_PLAYER-1:0] : p == 1 ? ~joystick2[BITS_PER_PLAYER-1:0] : '1;
  end
  // Load is level-sensitive, so it takes priority over a coincident clock edge.
  always_ff @(posedge clk)
    if (reset) begin
      r_sr <= '1;
      r_cnt <= CNT_END;
      r_done <= 1'b0;
    end else if (!w_load_lvl) begin
      r_sr <= w_par;
      r_cnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_clk_rise && r_cnt == CNT_END - 5'd1;
      if (w_clk_rise && r_cnt != CNT_END) begin
        r_sr <= {1'b1, r_sr[FL-1:1]};
        r_cnt <= r_cnt + 5'd1;
      end
    end
  assign JOY_DATA = r_sr[0];
  assign frame_done = r_done;
  assign bit_cnt = r_cnt;
  assign w_unused = ^{joystick1, joystick2, w_clk_lvl, w_clk_fall, w_load_rise, w_load_fall};
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed and randomised frames checked against a per-bit frame model.
module tb_joy_db15_tx;
`ifdef JOY_DB15_TX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, reset = 1'b1, JOY_CLK = 1'b0, JOY_LOAD = 1'b1, JOY_DATA, frame_done;
  logic [15:0] joystick1 = '0, joystick2 = '0, j1, j2;
  logic [4:0] bit_cnt;
  logic [23:0] gold;
  logic [11:0] rx1, rx2;
  logic frame [24];
  int n_vec = 0, n_err = 0, fd_cnt = 0, fd_base = 0, m_idx = 24;
  joy_db15_tx dut (
    .clk(clk), .reset(reset), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA),
    .frame_done(frame_done), .bit_cnt(bit_cnt)
  );
  always #10 clk = ~clk;
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    logic e;
    e = m_idx < 24 ? frame[m_idx] : 1'b1;
    chk({tag, ".data"}, 32'(JOY_DATA), 32'(e));
    chk({tag, ".cnt"}, 32'(bit_cnt), 32'(m_idx));
  endtask
  task automatic load(input logic [15:0] a, input logic [15:0] b);
    joystick1 = a;
    joystick2 = b;
    JOY_LOAD = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      frame[k] = ~a[k];
      frame[k+12] = ~b[k];
    end
    m_idx = 0;
    chk_state("load");
    JOY_LOAD = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk_state("post_load");
  endtask
  task automatic shift(input string tag);
    JOY_CLK = 1'b1;
    repeat (LAT) @(negedge clk);
    if (m_idx < 24) m_idx++;
    chk_state(tag);
    JOY_CLK = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst.data", 32'(JOY_DATA), 32'd1);
    chk("rst.cnt", 32'(bit_cnt), 32'd24);
    chk("rst.done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    shift("idle");
    chk("idle.fd", 32'(fd_cnt), 32'd0);
    gold = 24'h7FFFEE;
    load(16'h0011, 16'h0800);
    fd_base = fd_cnt;
    chk("seq0", 32'(JOY_DATA), 32'(gold[0]));
    JOY_CLK = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    chk("lat.early", 32'(bit_cnt), 32'd0);
    @(negedge clk);
    chk("lat.cnt", 32'(bit_cnt), 32'd1);
    m_idx = 1;
    JOY_CLK = 1'b0;
    repeat (LAT) @(negedge clk);
    for (int k = 1; k < 24; k++) begin
      chk("seq", 32'(JOY_DATA), 32'(gold[k]));
      shift("seq");
    end
    repeat (2) @(negedge clk);
    chk("seq.fd", 32'(fd_cnt - fd_base), 32'd1);
    repeat (6) shift("over");
    chk("over.fd", 32'(fd_cnt - fd_base), 32'd1);
    load(16'h0A5A, 16'h05A5);
    fd_base = fd_cnt;
    repeat (10) shift("mid");
    load(16'h0002, 16'h05A5);
    chk("mid.bit0", 32'(JOY_DATA), 32'd1);
    shift("mid2");
    chk("mid.bit1", 32'(JOY_DATA), 32'd0);
    chk("mid.fd", 32'(fd_cnt - fd_base), 32'd0);
    repeat (4) shift("col");
    JOY_CLK = 1'b1;
    JOY_LOAD = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("col.cnt", 32'(bit_cnt), 32'd0);
    chk("col.data", 32'(JOY_DATA), 32'd1);
    m_idx = 0;
    JOY_CLK = 1'b0;
    JOY_LOAD = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk_state("col.post");
    shift("col.first");
    load(16'($urandom), 16'($urandom));
    repeat (7) shift("rst7");
    fd_base = fd_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("rst7.data", 32'(JOY_DATA), 32'd1);
    chk("rst7.cnt", 32'(bit_cnt), 32'd24);
    chk("rst7.done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    m_idx = 24;
    repeat (20) shift("post_rst");
    repeat (2) @(negedge clk);
    chk("post_rst.fd", 32'(fd_cnt - fd_base), 32'd0);
    for (int f = 0; f < 6; f++) begin
      j1 = f == 0 ? 16'h0A5A : 16'($urandom);
      j2 = f == 0 ? 16'h05A5 : 16'($urandom);
      load(j1, j2);
      fd_base = fd_cnt;
      joystick1 = 16'($urandom);
      joystick2 = 16'($urandom);
      for (int k = 0; k < 24; k++) begin
        if (k < 12) rx1[k] = ~JOY_DATA;
        else rx2[k-12] = ~JOY_DATA;
        shift("rnd");
      end
      repeat (2) @(negedge clk);
      chk("rx1", 32'(rx1), 32'(j1[11:0]));
      chk("rx2", 32'(rx2), 32'(j2[11:0]));
      chk("rnd.fd", 32'(fd_cnt - fd_base), 32'd1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
